mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback formatter, directly downstream of `mem_stage`. It captures the memory read word and ALU result for the instruction leaving MEM, then applies load byte/halfword selection and sign or zero extension. It presents the final register-file write (index, data, enable) together with a forwarding tap for the hazard unit. It also keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 101 ++++++++++
 tb/tb_mem_wb_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, registers the writeback and forwarding tap, and counts retired instructions.
// Latency 1 cycle, all outputs straight from flops; stall holds the entry, flush loads a bubble and takes priority over stall.
module mem_wb_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_regwrite,
    input  logic            in_memtoreg,
    input  logic [2:0]      in_funct3,
    input  logic [RIDX-1:0] in_rd_idx,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    output logic            wb_valid,
    output logic            wb_regwrite,
    output logic [RIDX-1:0] wb_rd_idx,
    output logic [XLEN-1:0] wb_wdata,
    output logic            fwd_en,
    output logic [RIDX-1:0] fwd_rd_idx,
    output logic [XLEN-1:0] fwd_data,
    output logic [31:0]     instret
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [RIDX-1:0] rd_idx;
        logic [XLEN-1:0] wdata;
    } wb_entry_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    wb_entry_t       entry_q;
    wb_entry_t       entry_d;
    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic            advance;

    // Byte lane chosen by the low address bits; halfword by bit 1 only (bit 0 ignored, no misalignment trap).
    always_comb begin
        shifted  = in_mem_rdata >> {in_alu_result[1:0], 3'b000};
        byte_sel = shifted[7:0];
        half_sel = in_alu_result[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    end

    always_comb begin
        load_data = in_mem_rdata;
        case (in_funct3)
            F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = in_mem_rdata;
        endcase
    end

    always_comb begin
        entry_d          = '0;
        entry_d.valid    = in_valid;
        entry_d.regwrite = in_valid & in_regwrite & (in_rd_idx != '0);
        entry_d.rd_idx   = in_rd_idx;
        entry_d.wdata    = in_memtoreg ? load_data : in_alu_result;
    end

    // The current entry leaves whenever the register moves, so a held entry is counted once.
    assign advance = ~stall | flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
            instret <= '0;
        end else begin
            if (advance && entry_q.valid) begin
                instret <= instret + 32'd1;
            end
            if (flush) begin
                entry_q <= '0;
            end else if (!stall) begin
                entry_q <= entry_d;
            end
        end
    end

    assign wb_valid    = entry_q.valid;
    assign wb_regwrite = entry_q.regwrite;
    assign wb_rd_idx   = entry_q.rd_idx;
    assign wb_wdata    = entry_q.wdata;
    assign fwd_en      = entry_q.regwrite;
    assign fwd_rd_idx  = entry_q.rd_idx;
    assign fwd_data    = entry_q.wdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load formatting, x0 suppression, stall/flush and retire counting.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd_idx;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_wdata;
    logic        fwd_en;
    logic [4:0]  fwd_rd_idx;
    logic [31:0] fwd_data;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .RIDX(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_regwrite  (in_regwrite),
        .in_memtoreg  (in_memtoreg),
        .in_funct3    (in_funct3),
        .in_rd_idx    (in_rd_idx),
        .in_alu_result(in_alu_result),
        .in_mem_rdata (in_mem_rdata),
        .wb_valid     (wb_valid),
        .wb_regwrite  (wb_regwrite),
        .wb_rd_idx    (wb_rd_idx),
        .wb_wdata     (wb_wdata),
        .fwd_en       (fwd_en),
        .fwd_rd_idx   (fwd_rd_idx),
        .fwd_data     (fwd_data),
        .instret      (instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one instruction at the falling edge, clock it in, return at the next falling edge.
    task automatic apply(input logic v, input logic rw, input logic m2r, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata);
        in_valid      = v;
        in_regwrite   = rw;
        in_memtoreg   = m2r;
        in_funct3     = f3;
        in_rd_idx     = rd;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_entry(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                             input logic [31:0] wd, input logic [31:0] cnt);
        chk({tag, ".valid"},    {31'd0, wb_valid},    {31'd0, v});
        chk({tag, ".regwrite"}, {31'd0, wb_regwrite}, {31'd0, rw});
        chk({tag, ".rd"},       {27'd0, wb_rd_idx},   {27'd0, rd});
        chk({tag, ".wdata"},    wb_wdata,             wd);
        chk({tag, ".fwd_en"},   {31'd0, fwd_en},      {31'd0, rw});
        chk({tag, ".fwd_rd"},   {27'd0, fwd_rd_idx},  {27'd0, rd});
        chk({tag, ".fwd_data"}, fwd_data,             wd);
        chk({tag, ".instret"},  instret,              cnt);
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stall = 1'($urandom);
            flush = 1'($urandom);
            apply(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 5'($urandom),
                  $urandom, $urandom);
        end
        chk_entry("reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        // Load formatting; each valid entry is counted as the next one replaces it.
        apply(1, 1, 1, 3'b000, 5'd5, 32'h0000_1002, RD);
        chk_entry("lb",  1, 1, 5'd5, 32'hFFFFFFFF, 32'd0);
        apply(1, 1, 1, 3'b100, 5'd5, 32'h0000_1003, RD);
        chk_entry("lbu", 1, 1, 5'd5, 32'h00000080, 32'd1);
        apply(1, 1, 1, 3'b001, 5'd5, 32'h0000_1002, RD);
        chk_entry("lh",  1, 1, 5'd5, 32'hFFFF80FF, 32'd2);
        apply(1, 1, 1, 3'b101, 5'd5, 32'h0000_1000, RD);
        chk_entry("lhu", 1, 1, 5'd5, 32'h00007F01, 32'd3);
        apply(1, 1, 1, 3'b010, 5'd5, 32'h0000_1000, RD);
        chk_entry("lw",  1, 1, 5'd5, 32'h80FF7F01, 32'd4);
        apply(1, 1, 1, 3'b000, 5'd6, 32'h0000_1001, RD);
        chk_entry("lb_off1", 1, 1, 5'd6, 32'h0000007F, 32'd5);

        // ALU path ignores funct3; x0 and invalid instructions never write.
        apply(1, 1, 0, 3'b000, 5'd7, 32'h0000_1234, RD);
        chk_entry("alu", 1, 1, 5'd7, 32'h00001234, 32'd6);
        apply(1, 1, 0, 3'b000, 5'd0, 32'h0000_1234, RD);
        chk_entry("x0", 1, 0, 5'd0, 32'h00001234, 32'd7);
        apply(0, 1, 0, 3'b010, 5'd4, 32'h0000_0055, RD);
        chk_entry("invalid", 0, 0, 5'd4, 32'h00000055, 32'd8);

        // Stall: entry A held for three cycles against changing inputs.
        apply(1, 1, 0, 3'b010, 5'd9, 32'h0000_A5A5, RD);
        chk_entry("stallA", 1, 1, 5'd9, 32'h0000A5A5, 32'd8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 0, 3'b010, 5'(i + 1), 32'hDEAD_0000 + 32'(i), RD);
            chk_entry("stall_hold", 1, 1, 5'd9, 32'h0000A5A5, 32'd8);
        end
        stall = 1'b0;
        apply(1, 1, 0, 3'b010, 5'd3, 32'h0000_BEEF, RD);
        chk_entry("stall_release", 1, 1, 5'd3, 32'h0000BEEF, 32'd9);

        // Flush with stall: B retires, bubble loaded; a bubble is never counted.
        flush = 1'b1;
        stall = 1'b1;
        apply(1, 1, 1, 3'b010, 5'd12, 32'h0000_0C0C, RD);
        chk_entry("flush", 0, 0, 5'd0, 32'h0, 32'd10);
        flush = 1'b0;
        stall = 1'b0;
        apply(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
        chk_entry("bubble_idle", 0, 0, 5'd0, 32'h0, 32'd10);

        // Counter wrap from a preloaded value.
        apply(1, 1, 0, 3'b010, 5'd1, 32'h0000_0001, RD);
        force dut.instret = 32'hFFFF_FFFE;
        #1;
        release dut.instret;
        apply(1, 1, 0, 3'b010, 5'd2, 32'h0000_0002, RD);
        chk("wrap0", instret, 32'hFFFF_FFFF);
        apply(1, 1, 0, 3'b010, 5'd3, 32'h0000_0003, RD);
        chk("wrap1", instret, 32'h0000_0000);
        apply(1, 1, 0, 3'b010, 5'd4, 32'h0000_0004, RD);
        chk_entry("wrap2", 1, 1, 5'd4, 32'h00000004, 32'h0000_0001);

        // Mid-stream reset beats stall/flush and drops the pending entry uncounted.
        reset = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        apply(1, 1, 0, 3'b010, 5'd8, 32'h0000_0008, RD);
        chk_entry("midreset", 0, 0, 5'd0, 32'h0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
